// File: rtl/mux_nx1_reg_if.sv
// Channel-side and consumer-side signals of the registered N:1 multiplexer.
// The mux instance uses the slave modport; the producers/consumer use master.
interface mux_nx1_reg_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) ();
    logic [CHANNELS*WIDTH-1:0] din;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic                      mode;
    logic [WIDTH-1:0]          y;
    logic [SEL_W-1:0]          y_chan;
    logic                      y_valid;
    logic                      out_ready;
    logic                      sel_err;

    modport slave (
        input  din, in_valid, sel, mode, out_ready,
        output in_ready, y, y_chan, y_valid, sel_err
    );

    modport master (
        output din, in_valid, sel, mode, out_ready,
        input  in_ready, y, y_chan, y_valid, sel_err
    );
endinterface

// File: rtl/mux_nx1_reg.sv
// N-channel W-bit multiplexer with a one-word output register, direct or
// round-robin channel selection, and valid/ready handshakes on both sides.
module mux_nx1_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input logic            clk,
    input logic            rst,
    mux_nx1_reg_if.slave   bus
);

    logic             free;
    logic             sel_bad;
    logic             grant;
    logic [SEL_W-1:0] gidx;
    logic [WIDTH-1:0] gdata;
    logic [SEL_W-1:0] rr_ptr;
    int               k;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        free    = !bus.y_valid || bus.out_ready;
        sel_bad = (int'(bus.sel) >= CHANNELS);
        grant   = 1'b0;
        gidx    = '0;
        k       = 0;
        if (!bus.mode) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!sel_bad && bus.sel == SEL_W'(c) && bus.in_valid[c]) begin
                    grant = 1'b1;
                    gidx  = SEL_W'(c);
                end
            end
        end else begin
            // Search starts just after the last scan grant, so the most
            // recently served channel has the lowest priority.
            for (int i = 1; i <= CHANNELS; i++) begin
                k = (int'(rr_ptr) + i) % CHANNELS;
                if (!grant && bus.in_valid[k]) begin
                    grant = 1'b1;
                    gidx  = SEL_W'(k);
                end
            end
        end
        grant        = grant && free && !rst;
        gdata        = bus.din[int'(gidx)*WIDTH +: WIDTH];
        bus.in_ready = grant ? (CHANNELS'(1) << gidx) : '0;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.y       <= '0;
            bus.y_chan  <= '0;
            bus.y_valid <= 1'b0;
            bus.sel_err <= 1'b0;
            rr_ptr      <= SEL_W'(CHANNELS - 1);
        end else begin
            if (grant) begin
                bus.y       <= gdata;
                bus.y_chan  <= gidx;
                bus.y_valid <= 1'b1;
                if (bus.mode) begin
                    rr_ptr <= gidx;
                end
            end else if (free) begin
                bus.y_valid <= 1'b0;
            end
            if (!bus.mode && sel_bad && (|bus.in_valid)) begin
                bus.sel_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Self-checking bench: a 4-channel mux against a behavioural model on every
// cycle, plus directed checks on a 3-channel build for the bad-select flag.
module tb_mux_nx1_reg;

    localparam int C = 4;

    logic clk = 1'b0;
    logic rst4;
    logic rst3;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mux_nx1_reg_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) b4 ();
    mux_nx1_reg_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) b3 ();

    mux_nx1_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut4 (.clk(clk), .rst(rst4), .bus(b4));
    mux_nx1_reg #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (.clk(clk), .rst(rst3), .bus(b3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the 4-channel instance.
    logic [7:0] m_y     = '0;
    int         m_chan  = 0;
    logic       m_valid = 1'b0;
    logic       m_err   = 1'b0;
    int         m_last  = C - 1;

    function automatic int model_grant();
        if (rst4) return -1;
        if (m_valid && !b4.out_ready) return -1;
        if (!b4.mode) return (int'(b4.sel) < C && b4.in_valid[b4.sel]) ? int'(b4.sel) : -1;
        for (int d = 1; d <= C; d++) begin
            if (b4.in_valid[(m_last + d) % C]) return (m_last + d) % C;
        end
        return -1;
    endfunction

    initial begin
        int g;
        forever begin
            @(posedge clk);
            g = model_grant();
            if (rst4) begin
                m_y = '0; m_chan = 0; m_valid = 1'b0; m_err = 1'b0; m_last = C - 1;
            end else begin
                if (g >= 0) begin
                    m_y     = b4.din[g*8 +: 8];
                    m_chan  = g;
                    m_valid = 1'b1;
                    if (b4.mode) m_last = g;
                end else if (!m_valid || b4.out_ready) begin
                    m_valid = 1'b0;
                end
                if (!b4.mode && int'(b4.sel) >= C && (|b4.in_valid)) m_err = 1'b1;
            end
            @(negedge clk);
            g = model_grant();
            check("in_ready", 32'(b4.in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            check("y_valid", 32'(b4.y_valid), 32'(m_valid));
            check("y", 32'(b4.y), 32'(m_y));
            check("y_chan", 32'(b4.y_chan), 32'(m_chan));
            check("sel_err", 32'(b4.sel_err), 32'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bytes[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int         seq[6]   = '{0, 1, 3, 0, 1, 3};

    initial begin
        rst4 = 1'b1; rst3 = 1'b1;
        b4.din = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        b4.in_valid = 4'hF; b4.mode = 1'b1; b4.sel = 2'd0; b4.out_ready = 1'b1;
        b3.din = {8'h33, 8'h22, 8'h11};
        b3.in_valid = 3'b111; b3.mode = 1'b0; b3.sel = 2'd3; b3.out_ready = 1'b1;

        // Reset held for two cycles with all channels requesting.
        cyc(); cyc(); #3;
        check("rst_y", 32'(b4.y), 32'h0);
        check("rst_y_valid", 32'(b4.y_valid), 32'h0);
        check("rst_sel_err", 32'(b4.sel_err), 32'h0);
        check("rst_in_ready", 32'(b4.in_ready), 32'h0);

        // 3-channel build: out-of-range select sets a sticky error.
        cyc(); rst3 = 1'b0; #3;
        check("c3_no_grant", 32'(b3.in_ready), 32'h0);
        cyc(); #3;
        check("c3_sel_err", 32'(b3.sel_err), 32'h1);
        check("c3_y_valid", 32'(b3.y_valid), 32'h0);
        b3.sel = 2'd0;
        cyc(); #3;
        check("c3_err_sticky", 32'(b3.sel_err), 32'h1);
        check("c3_y", 32'(b3.y), 32'h11);
        rst3 = 1'b1;
        cyc(); #3;
        check("c3_err_cleared", 32'(b3.sel_err), 32'h0);

        // Release reset: channel 0 wins first.
        cyc(); rst4 = 1'b0; #3;
        check("first_grant", 32'(b4.in_ready), 32'h1);

        // Direct mode, select stepped 0..3.
        cyc(); b4.mode = 1'b0; b4.sel = 2'd0; #3;
        check("dir_y0", 32'(b4.y), 32'hAA);
        check("dir_rdy0", 32'(b4.in_ready), 32'h1);
        for (int i = 1; i < 4; i++) begin
            cyc(); b4.sel = 2'(i); #3;
            check("dir_y", 32'(b4.y), 32'(bytes[i-1]));
            check("dir_chan", 32'(b4.y_chan), 32'(i - 1));
            check("dir_rdy", 32'(b4.in_ready), 32'd1 << i);
        end
        cyc(); b4.in_valid = 4'h0; #3;
        check("dir_y3", 32'(b4.y), 32'hDD);
        check("dir_chan3", 32'(b4.y_chan), 32'h3);
        cyc(); #3;
        check("drain_valid", 32'(b4.y_valid), 32'h0);
        check("drain_y_hold", 32'(b4.y), 32'hDD);

        // Reset mid-stream, then scan fairness with channel 2 idle.
        cyc(); rst4 = 1'b1;
        cyc(); rst4 = 1'b0; b4.mode = 1'b1; b4.in_valid = 4'b1011; #3;
        check("scan_rdy0", 32'(b4.in_ready), 32'h1);
        check("scan_rst_y", 32'(b4.y), 32'h0);
        for (int j = 1; j < 6; j++) begin
            cyc(); #3;
            check("scan_chan", 32'(b4.y_chan), 32'(seq[j-1]));
            check("scan_rdy", 32'(b4.in_ready), 32'd1 << seq[j]);
        end

        // Wrap-around: pointer at 3, channel 3 again, then channel 0.
        cyc(); b4.in_valid = 4'b1000; #3;
        check("wrap_chan", 32'(b4.y_chan), 32'h3);
        check("wrap_rdy3", 32'(b4.in_ready), 32'h8);
        cyc(); b4.in_valid = 4'b0001; #3;
        check("wrap_rdy0", 32'(b4.in_ready), 32'h1);

        // Back-pressure: AA held three cycles, then BB with no gap.
        for (int r = 0; r < 3; r++) begin
            cyc(); b4.in_valid = 4'b0010; b4.out_ready = 1'b0; #3;
            check("bp_y", 32'(b4.y), 32'hAA);
            check("bp_valid", 32'(b4.y_valid), 32'h1);
            check("bp_rdy", 32'(b4.in_ready), 32'h0);
        end
        cyc(); b4.out_ready = 1'b1; #3;
        check("bp_release", 32'(b4.in_ready), 32'h2);
        cyc(); b4.in_valid = 4'h0; #3;
        check("bp_next_y", 32'(b4.y), 32'hBB);
        check("bp_next_valid", 32'(b4.y_valid), 32'h1);

        // Random traffic; the model-based compare runs every cycle.
        for (int n = 0; n < 400; n++) begin
            cyc();
            rst4         = ($urandom_range(0, 59) == 0);
            b4.din       = $urandom;
            b4.in_valid  = 4'($urandom);
            b4.mode      = ($urandom_range(0, 3) != 0);
            b4.sel       = 2'($urandom);
            b4.out_ready = ($urandom_range(0, 3) != 0);
        end
        cyc(); #3;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
